// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and sizing helper for the character-LCD
// frame writer and its bus-cycle timer.
package lcd_pkg;

    localparam int         LCD_CHARS         = 16;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_HOLD
    } lcd_phase_t;

    // Width of a 0..max(a,b)-1 phase counter, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780-style write transfer: SETUP (1 clk), EHIGH (lcd_e=1), HOLD (lcd_e=0).
// ack marks the last HOLD clock; a go in that clock chains the next transfer with no gap.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       ack,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int CNT_W = cnt_width(E_HIGH_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    lcd_phase_t       phase;
    logic [CNT_W-1:0] cnt;

    assign ack = (phase == PH_HOLD) && (cnt == HOLD_LAST);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= 8'h00;
        end else begin
            unique case (phase)
                PH_IDLE: begin
                    cnt <= '0;
                    if (go) begin
                        phase  <= PH_SETUP;
                        lcd_rs <= rs;
                        lcd_db <= data;
                    end
                end
                PH_SETUP: begin
                    phase <= PH_EHIGH;
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                end
                PH_EHIGH: begin
                    if (cnt == E_LAST) begin
                        phase <= PH_HOLD;
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (go) begin
                            phase  <= PH_SETUP;
                            lcd_rs <= rs;
                            lcd_db <= data;
                        end else begin
                            // Bus parks at rs=0, db=0x00 whenever no transfer is running.
                            phase  <= PH_IDLE;
                            lcd_rs <= 1'b0;
                            lcd_db <= 8'h00;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    phase  <= PH_IDLE;
                    cnt    <= '0;
                    lcd_e  <= 1'b0;
                    lcd_rs <= 1'b0;
                    lcd_db <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Writes a 16-character frame to a character LCD: the set-DDRAM-address command
// followed by the 16 latched bytes, sequenced over lcd_bus_cycle.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES   = 2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] frame,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_db
);

    localparam logic [3:0] LAST_IDX = 4'(LCD_CHARS - 1);

    lcd_state_t   state;
    logic [127:0] frame_reg;
    logic [3:0]   byte_idx;
    logic [3:0]   next_idx;

    logic       bus_go;
    logic       bus_rs;
    logic [7:0] bus_data;
    logic       bus_ack;

    assign lcd_rw   = 1'b0;
    assign next_idx = byte_idx + 4'd1;

    // What to load into the bus timer when it next accepts a transfer.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus_go   = 1'b0;
        bus_rs   = 1'b0;
        bus_data = 8'h00;
        unique case (state)
            ST_IDLE: begin
                bus_go   = start;
                bus_data = LCD_CMD_SET_DDRAM;
            end
            ST_CMD: begin
                bus_go   = bus_ack;
                bus_rs   = 1'b1;
                bus_data = frame_reg[7:0];
            end
            ST_DATA: begin
                bus_go   = bus_ack && (byte_idx != LAST_IDX);
                bus_rs   = 1'b1;
                bus_data = frame_reg[{next_idx, 3'b000} +: 8];
            end
            default: begin
                bus_go   = 1'b0;
                bus_rs   = 1'b0;
                bus_data = 8'h00;
            end
        endcase
    end

    // NOTE: the 128-bit frame register is a plain flop bank, not a RAM, so it
    // is cleared with everything else on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_reg <= '0;
            byte_idx  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_reg <= frame;
                        byte_idx  <= 4'd0;
                        busy      <= 1'b1;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (bus_ack) begin
                        byte_idx <= 4'd0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus_ack) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= 4'd0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                default: begin
                    byte_idx <= 4'd0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_HIGH_CYCLES (E_HIGH_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_bus (
        .clk    (clk),
        .reset  (reset),
        .go     (bus_go),
        .rs     (bus_rs),
        .data   (bus_data),
        .ack    (bus_ack),
        .lcd_rs (lcd_rs),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db)
    );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized scoreboard bench for lcd_frame_writer: a transaction-level model queues
// the expected 17 transfers per accepted start; a monitor checks them at each lcd_e rise.
module tb_lcd_frame_writer;

    localparam int E_HIGH     = 2;
    localparam int HOLD       = 3;
    localparam int XFER       = 1 + E_HIGH + HOLD;
    localparam int FRAME_CLKS = 17 * XFER;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] frame;
    logic         busy;
    logic         done;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_e;
    logic [7:0]   lcd_db;

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .E_HIGH_CYCLES (E_HIGH),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .frame  (frame),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db)
    );

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         at;
    } xfer_t;

    xfer_t exp_q[$];
    int    cyc         = 0;
    bit    model_busy  = 1'b0;
    int    busy_end    = -1;
    int    done_at     = -1;
    int    last_accept = 0;
    int    accepted    = 0;
    int    done_seen   = 0;
    int    n_checks    = 0;
    int    n_fail      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a start seen while idle begins a frame whose 17 lcd_e rises
    // land every XFER clocks, and whose done appears FRAME_CLKS clocks later.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (!model_busy && start) begin
                exp_q.push_back(xfer_t'{1'b0, 8'h80, cyc + 1});
                for (int k = 0; k < 16; k++)
                    exp_q.push_back(xfer_t'{1'b1, frame[8*k +: 8], cyc + 1 + XFER * (k + 1)});
                model_busy  = 1'b1;
                busy_end    = cyc + FRAME_CLKS;
                last_accept = cyc;
                accepted++;
            end else if (model_busy && cyc == busy_end) begin
                model_busy = 1'b0;
                done_at    = cyc;
            end
        end
    end

    // Monitor: samples on the falling clock edge, away from DUT updates.
    logic       prev_e = 1'b0;
    int         hi_cnt = 0;
    logic       held_rs;
    logic [7:0] held_db;
    xfer_t      got;

    always @(negedge clk) begin
        if (reset) begin
            prev_e = 1'b0;
            hi_cnt = 0;
        end else begin
            check("lcd_rw_zero", lcd_rw, 1'b0);
            check("busy", busy, model_busy);
            check("done", done, (cyc == done_at));
            if (done) done_seen++;
            if (!model_busy) begin
                check("idle_lcd_e", lcd_e, 1'b0);
                check("idle_lcd_rs", lcd_rs, 1'b0);
                check("idle_lcd_db", lcd_db, 8'h00);
            end
            if (lcd_e && !prev_e) begin
                check("xfer_expected", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("xfer_rs", lcd_rs, got.rs);
                    check("xfer_db", lcd_db, got.db);
                    check("xfer_time", cyc, got.at);
                end
                held_rs = lcd_rs;
                held_db = lcd_db;
                hi_cnt  = 1;
            end else if (lcd_e) begin
                hi_cnt++;
                check("stable_rs_ehigh", lcd_rs, held_rs);
                check("stable_db_ehigh", lcd_db, held_db);
            end else if (prev_e) begin
                check("e_high_width", hi_cnt, E_HIGH);
                check("stable_rs_fall", lcd_rs, held_rs);
                check("stable_db_fall", lcd_db, held_db);
            end
            prev_e = lcd_e;
        end
    end

    function automatic logic [127:0] rand_frame();
        logic [127:0] f;
        for (int i = 0; i < 4; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic pulse_start(input logic [127:0] f);
        @(negedge clk);
        frame = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((model_busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (model_busy || exp_q.size() != 0), 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_now();
        #2 reset = 1'b1;
        exp_q.delete();
        model_busy = 1'b0;
        busy_end   = -1;
        done_at    = -1;
        #1;
        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_db", lcd_db, 8'h00);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] f;
        int d0, a0, n, target;

        reset = 1'b0;
        start = 1'b0;
        frame = '0;
        @(negedge clk);
        reset_now();

        // Byte k holds k: command then 0x00..0x0F.
        for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'(k);
        d0 = done_seen;
        pulse_start(f);
        wait_idle(FRAME_CLKS + 20);
        check("t1_done_count", done_seen - d0, 1);

        // Frame changes and start re-pulses mid-write: both ignored.
        d0 = done_seen;
        a0 = accepted;
        pulse_start(rand_frame());
        repeat (29) @(negedge clk);
        frame = {16{8'hFF}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(FRAME_CLKS + 20);
        check("t2_done_count", done_seen - d0, accepted - a0);
        check("t2_one_done", done_seen - d0, 1);

        // start held high: three back-to-back frames, frame input churning.
        d0 = done_seen;
        a0 = accepted;
        @(negedge clk);
        frame = rand_frame();
        start = 1'b1;
        n = 0;
        while (accepted - a0 < 3 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            frame = rand_frame();
            n++;
        end
        start = 1'b0;
        check("t3_accept_timeout", (accepted - a0 >= 3), 1'b1);
        wait_idle(FRAME_CLKS + 20);
        check("t3_done_count", done_seen - d0, accepted - a0);

        // Reset during the EHIGH phase of byte 7, then a full frame after release.
        d0 = done_seen;
        pulse_start(rand_frame());
        target = last_accept + 1 + XFER * 8;
        n = 0;
        while (cyc < target && n < FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("t4_in_ehigh_byte7", lcd_e, 1'b1);
        reset_now();
        repeat (FRAME_CLKS / 2) @(negedge clk);
        check("t4_no_done_after_abort", done_seen - d0, 0);
        pulse_start(rand_frame());
        wait_idle(FRAME_CLKS + 20);
        check("t4_done_count", done_seen - d0, 1);

        // Random frames, random start widths and gaps.
        d0 = done_seen;
        a0 = accepted;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            frame = rand_frame();
            start = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                frame = rand_frame();
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle(2 * FRAME_CLKS + 20);
        end
        check("t5_done_count", done_seen - d0, accepted - a0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 SHALL have parameter E_HIGH_CYCLES, default 12, which sets the number of clocks lcd_e is held high per transfer (minimum 1).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2000, which sets the number of clocks lcd_e is held low after each falling edge, covering controller execution time (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port frame, input, 128 bits: 16 character codes; byte k is frame[8k+7:8k] and is displayed at column k.
REQ-006 SHALL have port start, input, 1 bit: request to write frame to the LCD.
REQ-007 SHALL have port busy, output, 1 bit: high while a frame write is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-clock pulse when a frame write completes.
REQ-009 SHALL have port lcd_rs, output, 1 bit: register select (0 = command, 1 = data).
REQ-010 SHALL have port lcd_rw, output, 1 bit: read/write select, tied to 0 (write only).
REQ-011 SHALL have port lcd_e, output, 1 bit: enable strobe.
REQ-012 SHALL have port lcd_db, output, 8 bits: data bus.

Function
REQ-013 SHALL accept start only in IDLE (busy=0), latching frame into an internal 128-bit register on that same edge; later changes to frame SHALL NOT affect the write in progress.
REQ-014 SHALL ignore start while busy=1, with no queuing.
REQ-015 SHALL issue 17 transfers per frame: first the command 0x80 (DDRAM address 0) with lcd_rs=0, then bytes 0..15 in ascending order with lcd_rs=1.
REQ-016 SHALL run each transfer through three phases: SETUP for 1 clock (lcd_rs and lcd_db driven, lcd_e=0), EHIGH for E_HIGH_CYCLES clocks (lcd_e=1), and HOLD for HOLD_CYCLES clocks (lcd_e=0); one transfer therefore takes 1+E_HIGH_CYCLES+HOLD_CYCLES clocks.
REQ-017 SHALL hold lcd_rs and lcd_db constant from SETUP through the end of HOLD of each transfer.
REQ-018 SHALL use the states IDLE -> CMD (transfer 0) -> DATA (transfers 1..16, byte index 0..15) -> IDLE; the transition from DATA to IDLE SHALL occur on the last HOLD clock when the byte index is 15.
REQ-019 SHALL assert busy from the clock after start is accepted until the return to IDLE, and SHALL keep it low in IDLE.
REQ-020 SHALL pulse done high for exactly the first IDLE clock after a frame completes, with busy=0 in that clock; a start in that clock SHALL be accepted.
REQ-021 SHALL provide a phase counter wide enough for max(E_HIGH_CYCLES, HOLD_CYCLES) and a 4-bit byte index; the byte index SHALL NOT wrap within a frame.
REQ-022 SHALL drive lcd_e only from a register (glitch-free).
REQ-023 SHALL drive lcd_db=0x00, lcd_rs=0 and lcd_e=0 while in IDLE.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, busy=0, done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, counters=0 and the frame register=0.
REQ-025 SHALL abort a write in progress when reset is asserted mid-frame, with no done pulse; after release, the next start SHALL begin again with the 0x80 command.

Structure
REQ-026 SHALL take the state encoding, LCD_CMD_SET_DDRAM=8'h80 and LCD_CHARS=16 from the shared package lcd_pkg.
REQ-027 SHALL implement the SETUP/EHIGH/HOLD timing of one transfer in the sub-module lcd_bus_cycle (inputs go, rs, data; output ack, asserted on the last HOLD clock), with lcd_frame_writer sequencing it.

Verification (E_HIGH_CYCLES=2, HOLD_CYCLES=3, so 6 clocks per transfer)
REQ-028 SHALL cover: frame=0x0F0E...0100 (byte k=k), start pulse -> 17 lcd_e rising edges (0x80 with rs=0, then 0x00..0x0F with rs=1), each lcd_e high 2 clocks, done 102 clocks after start is accepted.
REQ-029 SHALL cover: frame changed to all-0xFF and start re-pulsed at clock 30 of a write -> output bytes unchanged, no second frame issued, exactly one done pulse.
REQ-030 SHALL cover: start held high continuously -> back-to-back frames, start accepted in the done clock, a new 0x80 command after each done.
REQ-031 SHALL cover: reset asserted during the EHIGH phase of byte 7 -> lcd_e=0 and busy=0 immediately, no done; the next start yields the full 17-transfer sequence.
REQ-032 SHALL cover: an assertion check on every clock -> lcd_rw=0, and lcd_db/lcd_rs stable whenever lcd_e=1 and at its falling edge.
